// File: rtl/fetch_queue_if.sv
// Handshake bundle between IF, the fetch queue and ID.
// The slave modport is the queue itself; the master modport is the IF/ID side.
interface fetch_queue_if #(
  parameter int unsigned BUS_WD = 109,
  parameter int unsigned PTR_WD = 2
);
  logic              fs_to_ds_valid;
  logic [BUS_WD-1:0] fs_to_ds_bus;
  logic              fq_allowin;
  logic              flush;
  logic              ds_allowin;
  logic              fq_to_ds_valid;
  logic [BUS_WD-1:0] fq_to_ds_bus;
  logic [PTR_WD:0]   fq_count;
  logic              fq_almost_full;

  modport slave (
    input  fs_to_ds_valid,
    input  fs_to_ds_bus,
    input  flush,
    input  ds_allowin,
    output fq_allowin,
    output fq_to_ds_valid,
    output fq_to_ds_bus,
    output fq_count,
    output fq_almost_full
  );

  modport master (
    output fs_to_ds_valid,
    output fs_to_ds_bus,
    output flush,
    output ds_allowin,
    input  fq_allowin,
    input  fq_to_ds_valid,
    input  fq_to_ds_bus,
    input  fq_count,
    input  fq_almost_full
  );
endinterface

// File: rtl/fetch_queue.sv
// Circular instruction queue decoupling IF from ID; absorbs decode stalls and
// empties on any redirect flush. No same-cycle bypass from push to head.
module fetch_queue #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned BUS_WD = 109,
  parameter int unsigned PTR_WD = 2
) (
  input logic            clk,
  input logic            resetn,
  fetch_queue_if.slave   fq
);

  localparam int unsigned CntWd = PTR_WD + 1;
  localparam logic [CntWd-1:0] DepthCnt = CntWd'(DEPTH);

  logic [PTR_WD-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_WD-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntWd-1:0]  count_q, count_d;
  logic [BUS_WD-1:0] mem_q [DEPTH];

  logic allowin;
  logic head_valid;
  logic push;
  logic pop;

  // Flush masks both sides so nothing moves in the redirect cycle.
  assign allowin    = (count_q != DepthCnt) && !fq.flush;
  assign head_valid = (count_q != '0) && !fq.flush;
  assign push       = fq.fs_to_ds_valid && allowin;
  assign pop        = head_valid && fq.ds_allowin;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (fq.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_WD'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_WD'(1);
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + CntWd'(1);
        2'b01:   count_d = count_q - CntWd'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= fq.fs_to_ds_bus;
    end
  end

  assign fq.fq_allowin     = allowin;
  assign fq.fq_to_ds_valid = head_valid;
  assign fq.fq_to_ds_bus   = mem_q[rd_ptr_q];
  assign fq.fq_count       = count_q;
  assign fq.fq_almost_full = count_q >= (DepthCnt - CntWd'(1));

  a_no_push_full: assert property (@(posedge clk) disable iff (!resetn)
    push |-> (count_q != DepthCnt));
  a_no_pop_empty: assert property (@(posedge clk) disable iff (!resetn)
    pop |-> (count_q != '0));
  a_count_range: assert property (@(posedge clk) disable iff (!resetn)
    count_q <= DepthCnt);

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: driver applies vectors with hand-computed checks,
// a negedge monitor keeps an expected-packet queue and compares every head transfer.
module tb_fetch_queue;
  localparam int unsigned Depth = 4;
  localparam int unsigned BusWd = 109;
  localparam int unsigned PtrWd = 2;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;
  logic [BusWd-1:0] exp_q [$];

  fetch_queue_if #(.BUS_WD(BusWd), .PTR_WD(PtrWd)) fq_if ();

  fetch_queue #(.DEPTH(Depth), .BUS_WD(BusWd), .PTR_WD(PtrWd)) dut (
    .clk    (clk),
    .resetn (resetn),
    .fq     (fq_if.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [BusWd-1:0] mk(input logic [31:0] pc);
    return {13'h0ab, ~pc, pc ^ 32'h5a5a_0000, pc};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares outputs against the model, then advances the model
  // using the same inputs the DUT sees at the coming edge.
  always @(negedge clk) begin
    bit m_push, m_pop;
    if (!resetn) begin
      exp_q.delete();
    end else begin
      chk("mon_count", 64'(fq_if.fq_count), 64'(exp_q.size()));
      chk("mon_valid", 64'(fq_if.fq_to_ds_valid),
          64'((exp_q.size() != 0) && !fq_if.flush));
      chk("mon_allowin", 64'(fq_if.fq_allowin),
          64'((exp_q.size() != Depth) && !fq_if.flush));
      m_push = fq_if.fs_to_ds_valid && (exp_q.size() != Depth) && !fq_if.flush;
      m_pop  = (exp_q.size() != 0) && !fq_if.flush && fq_if.ds_allowin;
      if (m_pop && fq_if.fq_to_ds_valid) begin
        vectors++;
        if (fq_if.fq_to_ds_bus !== exp_q[0]) begin
          miscompares++;
          $display("FAIL mon_head_bus: got %0h expected %0h at %0t",
                   fq_if.fq_to_ds_bus, exp_q[0], $time);
        end
      end
      if (fq_if.flush) begin
        exp_q.delete();
      end else begin
        if (m_pop) void'(exp_q.pop_front());
        if (m_push) exp_q.push_back(fq_if.fs_to_ds_bus);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    fq_if.fs_to_ds_valid = 1'b0;
    fq_if.fs_to_ds_bus   = '0;
    fq_if.flush          = 1'b0;
    fq_if.ds_allowin     = 1'b0;
    cyc();
    cyc();
    resetn = 1'b1;
    #1;
    chk("rst_count", 64'(fq_if.fq_count), 64'd0);
    chk("rst_valid", 64'(fq_if.fq_to_ds_valid), 64'd0);
    chk("rst_allowin", 64'(fq_if.fq_allowin), 64'd1);
    chk("rst_afull", 64'(fq_if.fq_almost_full), 64'd0);

    // Fill with decode stalled.
    for (int i = 0; i < 4; i++) begin
      fq_if.fs_to_ds_valid = 1'b1;
      fq_if.fs_to_ds_bus   = mk(32'h1c00_0000 + 32'(4 * i));
      cyc();
      chk("fill_count", 64'(fq_if.fq_count), 64'(i + 1));
      chk("fill_afull", 64'(fq_if.fq_almost_full), 64'(i + 1 >= 3));
    end
    chk("full_allowin", 64'(fq_if.fq_allowin), 64'd0);
    fq_if.fs_to_ds_bus = mk(32'h1c00_0010);
    cyc();
    chk("full_hold_count", 64'(fq_if.fq_count), 64'd4);

    // Drain in order; IF holds the fifth packet.
    fq_if.fs_to_ds_valid = 1'b0;
    fq_if.ds_allowin     = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_valid", 64'(fq_if.fq_to_ds_valid), 64'd1);
      chk("drain_pc", 64'(fq_if.fq_to_ds_bus[31:0]), 64'(32'h1c00_0000 + 32'(4 * i)));
      cyc();
    end
    chk("drain_empty_valid", 64'(fq_if.fq_to_ds_valid), 64'd0);
    chk("drain_empty_count", 64'(fq_if.fq_count), 64'd0);

    // Streaming through the wrap point.
    for (int i = 0; i < 10; i++) begin
      fq_if.fs_to_ds_valid = 1'b1;
      fq_if.fs_to_ds_bus   = mk(32'h1c00_0010 + 32'(4 * i));
      cyc();
      chk("stream_count", 64'(fq_if.fq_count), 64'd1);
      chk("stream_pc", 64'(fq_if.fq_to_ds_bus[31:0]), 64'(32'h1c00_0010 + 32'(4 * i)));
    end
    fq_if.fs_to_ds_valid = 1'b0;
    cyc();
    chk("stream_end_count", 64'(fq_if.fq_count), 64'd0);

    // Full with simultaneous pop request.
    fq_if.ds_allowin = 1'b0;
    for (int i = 0; i < 4; i++) begin
      fq_if.fs_to_ds_valid = 1'b1;
      fq_if.fs_to_ds_bus   = mk(32'h1c00_0100 + 32'(4 * i));
      cyc();
    end
    fq_if.fs_to_ds_bus = mk(32'h1c00_0110);
    fq_if.ds_allowin   = 1'b1;
    #1;
    chk("fullpop_allowin", 64'(fq_if.fq_allowin), 64'd0);
    cyc();
    chk("fullpop_count", 64'(fq_if.fq_count), 64'd3);
    chk("fullpop_allowin_next", 64'(fq_if.fq_allowin), 64'd1);
    chk("fullpop_head", 64'(fq_if.fq_to_ds_bus[31:0]), 64'h1c00_0104);
    fq_if.fs_to_ds_bus = mk(32'h1c00_0114);
    cyc();
    chk("pushpop_count", 64'(fq_if.fq_count), 64'd3);
    chk("pushpop_head", 64'(fq_if.fq_to_ds_bus[31:0]), 64'h1c00_0108);

    // Flush at count 3 with a packet offered.
    fq_if.flush        = 1'b1;
    fq_if.fs_to_ds_bus = mk(32'h1c00_0118);
    #1;
    chk("flush_valid", 64'(fq_if.fq_to_ds_valid), 64'd0);
    chk("flush_allowin", 64'(fq_if.fq_allowin), 64'd0);
    cyc();
    fq_if.flush          = 1'b0;
    fq_if.fs_to_ds_valid = 1'b1;
    fq_if.fs_to_ds_bus   = mk(32'h1c00_8000);
    fq_if.ds_allowin     = 1'b0;
    chk("flush_count", 64'(fq_if.fq_count), 64'd0);
    cyc();
    fq_if.fs_to_ds_valid = 1'b0;
    chk("redirect_count", 64'(fq_if.fq_count), 64'd1);
    chk("redirect_head", 64'(fq_if.fq_to_ds_bus[31:0]), 64'h1c00_8000);

    // Drain, then flush an empty queue.
    fq_if.ds_allowin = 1'b1;
    cyc();
    fq_if.flush = 1'b1;
    cyc();
    fq_if.flush = 1'b0;
    chk("flush_empty_count", 64'(fq_if.fq_count), 64'd0);

    // Asynchronous reset between edges with count 2.
    fq_if.ds_allowin = 1'b0;
    for (int i = 0; i < 2; i++) begin
      fq_if.fs_to_ds_valid = 1'b1;
      fq_if.fs_to_ds_bus   = mk(32'h1c00_0200 + 32'(4 * i));
      cyc();
    end
    fq_if.fs_to_ds_valid = 1'b0;
    chk("pre_rst_count", 64'(fq_if.fq_count), 64'd2);
    #1;
    resetn = 1'b0;
    #1;
    chk("async_rst_count", 64'(fq_if.fq_count), 64'd0);
    chk("async_rst_valid", 64'(fq_if.fq_to_ds_valid), 64'd0);
    cyc();
    resetn = 1'b1;
    #1;
    chk("post_rst_allowin", 64'(fq_if.fq_allowin), 64'd1);
    chk("post_rst_count", 64'(fq_if.fq_count), 64'd0);
    fq_if.fs_to_ds_valid = 1'b1;
    fq_if.fs_to_ds_bus   = mk(32'h1c00_0300);
    cyc();
    fq_if.fs_to_ds_valid = 1'b0;
    chk("post_rst_head", 64'(fq_if.fq_to_ds_bus[31:0]), 64'h1c00_0300);
    fq_if.ds_allowin = 1'b1;
    cyc();
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
